// File: rtl/lru_victim_tracker_if.sv
// Request/response bundle between the cache replacement controller and the
// per-set LRU victim tracker.
interface lru_victim_tracker_if #(
  parameter int SET_BITS = 3
);
  logic                acc_en;
  logic [SET_BITS-1:0] acc_set;
  logic [1:0]          acc_way;
  logic                acc_fill;
  logic                inv_en;
  logic [SET_BITS-1:0] inv_set;
  logic [1:0]          inv_way;
  logic                lk_en;
  logic [SET_BITS-1:0] lk_set;
  logic [3:0]          victim_vec;
  logic                victim_valid;

  modport master (
    output acc_en, acc_set, acc_way, acc_fill,
    output inv_en, inv_set, inv_way,
    output lk_en, lk_set,
    input  victim_vec, victim_valid
  );

  modport slave (
    input  acc_en, acc_set, acc_way, acc_fill,
    input  inv_en, inv_set, inv_way,
    input  lk_en, lk_set,
    output victim_vec, victim_valid
  );
endinterface

// File: rtl/lru_victim_tracker.sv
// Per-set 4-way LRU age tracker; emits a registered, never-zero victim
// candidate vector for the lowest-set-bit priority encoder.
module lru_victim_tracker #(
  parameter int SET_BITS = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  lru_victim_tracker_if.slave bus
);

  localparam int NSETS = 1 << SET_BITS;

  typedef logic [3:0][1:0] set_age_t;

  set_age_t   age_q   [NSETS];
  set_age_t   age_d   [NSETS];
  logic [3:0] valid_q [NSETS];
  logic [3:0] valid_d [NSETS];

  logic [3:0] victim_vec_q, victim_vec_d;
  logic       victim_valid_q, victim_valid_d;

  logic [1:0] acc_age;
  logic       inv_take;

  // Set-state update: access first; an invalidate to the same set is dropped.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    age_d    = age_q;
    valid_d  = valid_q;
    acc_age  = age_q[bus.acc_set][bus.acc_way];
    inv_take = bus.inv_en && !(bus.acc_en && (bus.acc_set == bus.inv_set));

    if (bus.acc_en) begin
      for (int w = 0; w < 4; w++) begin
        if (age_q[bus.acc_set][w] < acc_age) begin
          age_d[bus.acc_set][w] = age_q[bus.acc_set][w] + 2'd1;
        end
      end
      age_d[bus.acc_set][bus.acc_way] = 2'd0;
      if (bus.acc_fill) begin
        valid_d[bus.acc_set][bus.acc_way] = 1'b1;
      end
    end

    if (inv_take) begin
      valid_d[bus.inv_set][bus.inv_way] = 1'b0;
    end
  end

  set_age_t   lk_age;
  logic [3:0] lk_valid;
  logic [3:0] cand;

  // Lookup reads the post-update state so a same-cycle write is never missed.
  always_comb begin
    lk_age   = age_d[bus.lk_set];
    lk_valid = valid_d[bus.lk_set];
    cand     = 4'b0000;
    if (lk_valid != 4'b1111) begin
      cand = ~lk_valid;
    end else begin
      for (int w = 0; w < 4; w++) begin
        cand[w] = (lk_age[w] == 2'd3);
      end
    end
    victim_valid_d = bus.lk_en;
    victim_vec_d   = bus.lk_en ? cand : victim_vec_q;
  end

  // NOTE: the age/valid arrays are plain flops, so they take the async reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NSETS; s++) begin
        for (int w = 0; w < 4; w++) begin
          age_q[s][w] <= 2'(w);
        end
        valid_q[s] <= 4'b0000;
      end
      victim_vec_q   <= 4'b0000;
      victim_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      age_q          <= age_d;
      valid_q        <= valid_d;
      victim_vec_q   <= victim_vec_d;
      victim_valid_q <= victim_valid_d;
    end
  end

  assign bus.victim_vec   = victim_vec_q;
  assign bus.victim_valid = victim_valid_q;

endmodule

// File: tb/tb_lru_victim_tracker.sv
// Directed and randomized checks of lru_victim_tracker against hand-computed
// vectors and a small behavioural LRU model.
module tb_lru_victim_tracker;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  lru_victim_tracker_if #(.SET_BITS(3)) bus ();

  lru_victim_tracker #(.SET_BITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int m_age [8][4];
  bit m_val [8][4];

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.acc_en = 1'b0; bus.acc_set = '0; bus.acc_way = '0; bus.acc_fill = 1'b0;
    bus.inv_en = 1'b0; bus.inv_set = '0; bus.inv_way = '0;
    bus.lk_en  = 1'b0; bus.lk_set  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input int s, input int w, input bit fill);
    bus.acc_en = 1'b1; bus.acc_set = 3'(s); bus.acc_way = 2'(w); bus.acc_fill = fill;
  endtask

  task automatic inv(input int s, input int w);
    bus.inv_en = 1'b1; bus.inv_set = 3'(s); bus.inv_way = 2'(w);
  endtask

  task automatic lk(input int s);
    bus.lk_en = 1'b1; bus.lk_set = 3'(s);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 4; w++) begin
        m_age[s][w] = w;
        m_val[s][w] = 1'b0;
      end
  endtask

  task automatic model_step(input bit ae, input int as, input int aw, input bit af,
                            input bit ie, input int is, input int iw);
    int a;
    if (ae) begin
      a = m_age[as][aw];
      for (int w = 0; w < 4; w++)
        if (m_age[as][w] < a) m_age[as][w] = m_age[as][w] + 1;
      m_age[as][aw] = 0;
      if (af) m_val[as][aw] = 1'b1;
    end
    if (ie && !(ae && as == is)) m_val[is][iw] = 1'b0;
  endtask

  function automatic logic [3:0] model_vec(input int s);
    logic [3:0] v;
    v = 4'b0000;
    for (int w = 0; w < 4; w++) if (!m_val[s][w]) v[w] = 1'b1;
    if (v == 4'b0000)
      for (int w = 0; w < 4; w++) if (m_age[s][w] == 3) v[w] = 1'b1;
    return v;
  endfunction

  function automatic bit model_perm_ok(input int s);
    bit [3:0] seen;
    seen = '0;
    for (int w = 0; w < 4; w++) seen[m_age[s][w]] = 1'b1;
    return seen == 4'b1111;
  endfunction

  initial begin
    bit ae, af, ie, le;
    int as, aw, is, iw, ls;
    total = 0;
    bad   = 0;
    idle();
    rst_n = 1'b0;
    #22 rst_n = 1'b1;
    #1;
    check("reset_vec", bus.victim_vec, 4'b0000);
    check("reset_valid", {3'b0, bus.victim_valid}, 4'b0000);

    // 1: lookup right after reset, then hold
    lk(0); tick(); idle();
    check("t1_valid", {3'b0, bus.victim_valid}, 4'b0001);
    check("t1_vec", bus.victim_vec, 4'b1111);
    tick();
    check("t1_valid_drop", {3'b0, bus.victim_valid}, 4'b0000);
    check("t1_vec_hold", bus.victim_vec, 4'b1111);

    // 2: fill set 2 ways 0..3; lookup in the last fill cycle sees the bypass
    acc(2, 0, 1); tick();
    acc(2, 1, 1); tick();
    acc(2, 2, 1); tick();
    acc(2, 3, 1); lk(2); tick(); idle();
    check("t2_bypass", bus.victim_vec, 4'b0001);
    lk(2); tick(); idle();
    check("t2_vec", bus.victim_vec, 4'b0001);

    // 3: hit way 0 -> ages w0:0 w1:3 w2:2 w3:1
    acc(2, 0, 0); tick(); idle();
    lk(2); tick(); idle();
    check("t3_vec", bus.victim_vec, 4'b0010);

    // 4: invalidate ways 2 and 3 separately; then refill to expose ages
    inv(2, 2); tick(); idle();
    inv(2, 3); tick(); idle();
    lk(2); tick(); idle();
    check("t4_vec", bus.victim_vec, 4'b1100);
    acc(2, 2, 1); lk(2); tick(); idle();
    check("t4_refill2", bus.victim_vec, 4'b1000);
    acc(2, 3, 1); lk(2); tick(); idle();
    check("t4_refill3", bus.victim_vec, 4'b0010);

    // hit on an invalid way must not set valid
    acc(3, 1, 0); lk(3); tick(); idle();
    check("hit_invalid", bus.victim_vec, 4'b1111);
    acc(3, 0, 1); tick();
    acc(3, 2, 1); tick();
    acc(3, 3, 1); lk(3); tick(); idle();
    check("hit_invalid_fill", bus.victim_vec, 4'b0010);

    // 5: same-set invalidate is dropped
    acc(5, 1, 1); inv(5, 3); lk(5); tick(); idle();
    check("t5_same_set", bus.victim_vec, 4'b1101);
    acc(6, 3, 1); lk(6); tick(); idle();
    check("t5_set6_fill", bus.victim_vec, 4'b0111);
    acc(5, 2, 1); inv(6, 3); lk(6); tick(); idle();
    check("t5_diff_set_inv", bus.victim_vec, 4'b1111);
    lk(5); tick(); idle();
    check("t5_diff_set_acc", bus.victim_vec, 4'b1001);

    // 6: randomized run against the model, with a reset pulse mid-run
    rst_n = 1'b0;
    #1;
    check("rand_reset_vec", bus.victim_vec, 4'b0000);
    tick();
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        idle();
        rst_n = 1'b0;
        #1;
        check("mid_reset_valid", {3'b0, bus.victim_valid}, 4'b0000);
        check("mid_reset_vec", bus.victim_vec, 4'b0000);
        tick();
        rst_n = 1'b1;
        model_reset();
      end
      ae = 1'($urandom_range(0, 1)); as = $urandom_range(0, 7);
      aw = $urandom_range(0, 3);     af = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 3) == 0); is = $urandom_range(0, 7);
      iw = $urandom_range(0, 3);
      le = 1'($urandom_range(0, 1)); ls = $urandom_range(0, 7);
      bus.acc_en = ae; bus.acc_set = 3'(as); bus.acc_way = 2'(aw); bus.acc_fill = af;
      bus.inv_en = ie; bus.inv_set = 3'(is); bus.inv_way = 2'(iw);
      bus.lk_en  = le; bus.lk_set  = 3'(ls);
      tick();
      model_step(ae, as, aw, af, ie, is, iw);
      if (ae && !model_perm_ok(as)) $fatal(1, "FAIL model_perm set=%0d", as);
      if (le) begin
        check("rand_valid", {3'b0, bus.victim_valid}, 4'b0001);
        check("rand_vec", bus.victim_vec, model_vec(ls));
        total++;
        assert (bus.victim_vec !== 4'b0000) else begin
          bad++;
          $error("FAIL rand_nonzero observed=%b expected=nonzero", bus.victim_vec);
        end
      end else begin
        check("rand_idle", {3'b0, bus.victim_valid}, 4'b0000);
      end
    end
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
